// File: rtl/debounce_scheduler.sv
// rtl/debounce_scheduler.sv - round-robin button debouncer sharing a single timer, with a one-entry event slot
// Optional feature macro: DEBOUNCE_RELEASE_EVENT_EN (release commits also load the event slot and may stall)
module debounce_scheduler #(
    parameter int NUM_BTN       = 4,
    parameter int ID_W          = 2,
    parameter int DEBOUNCE_TIME = 45000,
    parameter int COUNTER_LEN   = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_state,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic               event_valid,
    input  logic               event_ready,
    output logic [ID_W-1:0]    event_id,
    output logic               event_level
);

    localparam logic [1:0] S_SCAN   = 2'd0;
    localparam logic [1:0] S_TIMING = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [COUNTER_LEN-1:0] TIMER_LAST = COUNTER_LEN'(DEBOUNCE_TIME - 1);
    localparam logic [ID_W-1:0]        LAST_CH    = ID_W'(NUM_BTN - 1);

    logic [NUM_BTN-1:0]     r_sync1;
    logic [NUM_BTN-1:0]     r_sync2;
    logic [NUM_BTN-1:0]     r_btn_state;
    logic [NUM_BTN-1:0]     r_press_pulse;
    logic [1:0]             r_state;
    logic [ID_W-1:0]        r_grant;
    logic [ID_W-1:0]        r_last_grant;
    logic [COUNTER_LEN-1:0] r_timer;
    logic                   r_event_valid;
    logic [ID_W-1:0]        r_event_id;
    logic                   r_event_level;

    logic [NUM_BTN-1:0]     w_pending;
    logic                   w_any_pending;
    logic [ID_W-1:0]        w_next_grant;
    logic [ID_W-1:0]        w_idx;
    logic                   w_grant_sync;
    logic                   w_grant_state;
    logic                   w_new_level;
    logic                   w_needs_slot;
    logic                   w_slot_free;
    logic                   w_commit;
    logic                   w_load;

    assign w_pending     = r_sync2 ^ r_btn_state;
    assign w_any_pending = |w_pending;

    // Walk downward so the pending channel closest after last_grant is written last and wins.
    always_comb begin
        w_next_grant = r_last_grant;
        w_idx        = r_last_grant;
        for (int k = NUM_BTN; k >= 1; k--) begin
            w_idx = ID_W'((int'(r_last_grant) + k) % NUM_BTN);
            if (w_pending[w_idx]) begin
                w_next_grant = w_idx;
            end
        end
    end

    assign w_grant_sync  = r_sync2[r_grant];
    assign w_grant_state = r_btn_state[r_grant];
    assign w_new_level   = ~w_grant_state;

`ifdef DEBOUNCE_RELEASE_EVENT_EN
    assign w_needs_slot = 1'b1;
`else
    assign w_needs_slot = w_new_level;
`endif

    // A change that does not need the slot never waits; one that does waits for a free or draining slot.
    assign w_slot_free = ~r_event_valid | event_ready;
    assign w_commit    = (r_state == S_COMMIT) && (~w_needs_slot || w_slot_free);
    assign w_load      = w_commit && w_needs_slot;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_SCAN;
            r_grant      <= '0;
            r_last_grant <= LAST_CH;
            r_timer      <= '0;
        end else begin
            case (r_state)
                S_SCAN: begin
                    if (w_any_pending) begin
                        r_grant <= w_next_grant;
                        r_timer <= '0;
                        r_state <= S_TIMING;
                    end
                end
                S_TIMING: begin
                    if (w_grant_sync == w_grant_state) begin
                        r_last_grant <= r_grant;
                        r_state      <= S_SCAN;
                    end else if (r_timer == TIMER_LAST) begin
                        r_state <= S_COMMIT;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_COMMIT: begin
                    // The change is already qualified, so a stall never re-examines the input.
                    if (w_commit) begin
                        r_last_grant <= r_grant;
                        r_state      <= S_SCAN;
                    end
                end
                default: begin
                    r_state <= S_SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_state   <= '0;
            r_press_pulse <= '0;
        end else begin
            r_press_pulse <= '0;
            if (w_commit) begin
                r_btn_state[r_grant]   <= w_new_level;
                r_press_pulse[r_grant] <= w_new_level;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_event_valid <= 1'b0;
            r_event_id    <= '0;
            r_event_level <= 1'b0;
        end else if (w_load) begin
            r_event_valid <= 1'b1;
            r_event_id    <= r_grant;
            r_event_level <= w_new_level;
        end else if (r_event_valid && event_ready) begin
            r_event_valid <= 1'b0;
        end
    end

    assign btn_state   = r_btn_state;
    assign press_pulse = r_press_pulse;
    assign event_valid = r_event_valid;
    assign event_id    = r_event_id;
    assign event_level = r_event_level;

endmodule

// File: tb/tb_debounce_scheduler.sv
// tb/tb_debounce_scheduler.sv - directed bench with a cycle-level behavioural model for debounce_scheduler
module tb_debounce_scheduler;

    localparam int NB = 4;
    localparam int DT = 8;
`ifdef DEBOUNCE_RELEASE_EVENT_EN
    localparam bit REL_EV = 1'b1;
`else
    localparam bit REL_EV = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_in;
    logic [NB-1:0] btn_state;
    logic [NB-1:0] press_pulse;
    logic          event_valid;
    logic          event_ready;
    logic [1:0]    event_id;
    logic          event_level;

    int n_checks = 0;
    int n_err    = 0;
    bit started  = 1'b0;
    int pulse_cnt = 0;
    logic [2:0] hs_q[$];

    debounce_scheduler #(
        .NUM_BTN(NB), .ID_W(2), .DEBOUNCE_TIME(DT), .COUNTER_LEN(4)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .btn_state(btn_state), .press_pulse(press_pulse),
        .event_valid(event_valid), .event_ready(event_ready),
        .event_id(event_id), .event_level(event_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: a granted channel must look different for DT cycles after its grant, then waits for the slot.
    logic [NB-1:0] m_s1, m_s2, m_lvl, m_pulse;
    logic          m_ev_valid, m_ev_lvl;
    logic [1:0]    m_ev_id;
    int            m_cur, m_last, m_since, cyc = 0;
    bit            m_wait;

    always @(posedge clk) begin
        logic [NB-1:0] pend, nxt_pulse;
        bit drain, load, needs, newl;
        int c;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0;
            m_ev_valid = 1'b0; m_ev_id = 2'd0; m_ev_lvl = 1'b0;
            m_cur = -1; m_wait = 1'b0; m_last = NB - 1; m_since = 0;
        end else begin
            pend = m_s2 ^ m_lvl;
            nxt_pulse = '0;
            load = 1'b0;
            drain = m_ev_valid && event_ready;
            if (m_cur < 0) begin
                if (pend != '0) begin
                    for (int k = 1; k <= NB; k++) begin
                        c = (m_last + k) % NB;
                        if (pend[c] && m_cur < 0) m_cur = c;
                    end
                    m_since = cyc;
                    m_wait = 1'b0;
                end
            end else if (!m_wait) begin
                if (m_s2[m_cur] == m_lvl[m_cur]) begin
                    m_last = m_cur;
                    m_cur = -1;
                end else if (cyc - m_since == DT) begin
                    m_wait = 1'b1;
                end
            end else begin
                newl = !m_lvl[m_cur];
                needs = REL_EV || newl;
                if (!needs || !m_ev_valid || event_ready) begin
                    m_lvl[m_cur] = newl;
                    nxt_pulse[m_cur] = newl;
                    if (needs) begin
                        load = 1'b1;
                        m_ev_id = 2'(m_cur);
                        m_ev_lvl = newl;
                    end
                    m_last = m_cur;
                    m_cur = -1;
                end
            end
            if (load) m_ev_valid = 1'b1;
            else if (drain) m_ev_valid = 1'b0;
            m_pulse = nxt_pulse;
            m_s2 = m_s1;
            m_s1 = btn_in;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (started) begin
            check("cycle_model", {btn_state, press_pulse, event_valid, event_id, event_level},
                  {m_lvl, m_pulse, m_ev_valid, m_ev_id, m_ev_lvl});
            pulse_cnt += $countones(press_pulse);
        end
    end

    always @(negedge clk) begin
        #2;
        if (!reset && event_valid && event_ready) hs_q.push_back({event_id, event_level});
    end

    task automatic edges_until(input logic [NB-1:0] mask, input logic lvl, input int maxc, output int n);
        n = -1;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            if ((btn_state & mask) == (lvl ? mask : '0)) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n, t2, t3;
        reset = 1'b1; btn_in = '0; event_ready = 1'b1;
        repeat (3) @(negedge clk);
        started = 1'b1;
        check("reset_outputs", {btn_state, press_pulse, event_valid, event_id, event_level}, 12'h000);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Clean press on channel 0
        pulse_cnt = 0; hs_q.delete();
        btn_in = 4'b0001;
        edges_until(4'b0001, 1'b1, 20, n);
        check("press_latency", n, 12);
        repeat (3) @(negedge clk);
        check("press_pulse_count", pulse_cnt, 1);
        check("press_event_count", hs_q.size(), 1);
        if (hs_q.size() >= 1) check("press_event", hs_q[0], 3'b001);

        // Bounce on channel 1
        pulse_cnt = 0; hs_q.delete();
        btn_in = 4'b0011;
        repeat (5) @(negedge clk);
        btn_in = 4'b0001;
        repeat (20) @(negedge clk);
        check("bounce_state", btn_state, 4'b0001);
        check("bounce_pulses", pulse_cnt, 0);
        check("bounce_events", hs_q.size(), 0);

        // Channels 2 and 3 together
        hs_q.delete(); t2 = -1; t3 = -1;
        btn_in = 4'b1101;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (t2 < 0 && btn_state[2]) t2 = k;
            if (t3 < 0 && btn_state[3]) t3 = k;
        end
        check("simul_ch2_edge", t2, 12);
        check("simul_ch3_edge", t3, 22);
        check("simul_event_count", hs_q.size(), 2);
        if (hs_q.size() >= 2) begin
            check("simul_event0", hs_q[0], 3'b101);
            check("simul_event1", hs_q[1], 3'b111);
        end

        // Release channel 0
        hs_q.delete();
        btn_in = 4'b1100;
        edges_until(4'b0001, 1'b0, 20, n);
        check("release_latency", n, 12);
        repeat (3) @(negedge clk);
        check("release_state", btn_state, 4'b1100);
        check("release_events", hs_q.size(), REL_EV ? 1 : 0);

        // Reset while channel 1 is timing (timer reaches 4 after 7 edges)
        btn_in = 4'b1110;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_outputs", {btn_state, press_pulse, event_valid, event_id, event_level}, 12'h000);
        reset = 1'b0;
        edges_until(4'b0010, 1'b1, 30, n);
        check("midreset_requalify", n, 12);
        repeat (25) @(negedge clk);
        check("midreset_final", btn_state, 4'b1110);

        // Backpressure
        btn_in = '0; reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0; event_ready = 1'b0; hs_q.delete();
        btn_in = 4'b0001;
        edges_until(4'b0001, 1'b1, 20, n);
        check("bp_first_latency", n, 12);
        check("bp_first_event", {event_valid, event_id, event_level}, 4'b1001);
        btn_in = 4'b0011;
        repeat (20) @(negedge clk);
        check("bp_stall_state", btn_state, 4'b0001);
        check("bp_stall_event", {event_valid, event_id, event_level}, 4'b1001);
        event_ready = 1'b1;
        @(negedge clk);
        check("bp_swap_event", {event_valid, event_id, event_level}, 4'b1011);
        check("bp_swap_state", btn_state, 4'b0011);
        check("bp_swap_pulse", press_pulse, 4'b0010);
        @(negedge clk);
        check("bp_drained", event_valid, 1'b0);
        check("bp_event_count", hs_q.size(), 2);
        if (hs_q.size() >= 2) begin
            check("bp_event0", hs_q[0], 3'b001);
            check("bp_event1", hs_q[1], 3'b011);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
